// File: rtl/ad1_pkg.sv
`default_nettype none
// ============================================================================
// Package : ad1_pkg
// Brief   : Shared state encoding, response codes and sample packing for the
//           Pmod AD1 AXI-Lite poller.
// Rev     : 1.0 - initial release
// ============================================================================
package ad1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR0  = 3'd1,
    ST_R0   = 3'd2,
    ST_AR1  = 3'd3,
    ST_R1   = 3'd4,
    ST_PUSH = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CH_W     = 12;
  localparam int CH0_LSB  = 0;
  localparam int CH1_LSB  = 16;
  localparam int SAMPLE_W = 32;

  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [CH_W-1:0] ch0,
                                                      input logic [CH_W-1:0] ch1);
    logic [SAMPLE_W-1:0] w;
    w = '0;
    w[CH0_LSB +: CH_W] = ch0;
    w[CH1_LSB +: CH_W] = ch1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad1_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module : ad1_sample_fifo
// Brief  : Synchronous FIFO with a registered first-word-fall-through head.
// Rev    : 1.0 - initial release
// ============================================================================
module ad1_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  C_FULL   = DEPTH[AW:0];
  localparam logic [AW:0]  C_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] C_PSTEP = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_FULL);
  assign level     = r_count;
  assign dout      = r_dout;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PSTEP;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PSTEP;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      // The head register takes the incoming word only when it becomes the oldest entry.
      if (w_do_push && (empty || (r_count == C_ONE && w_do_pop)))
        r_dout <= din;
      else if (w_do_pop && (r_count > C_ONE))
        r_dout <= r_mem[r_rd_ptr + C_PSTEP];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ad1_axi_poller.sv
`default_nettype none
// ============================================================================
// Module : ad1_axi_poller
// Brief  : AXI4-Lite read master polling the Pmod AD1 CH0/CH1 registers into a
//          sample stream. Define AD1_AXI_POLLER_TIMESTAMP_EN to add m_axis_tuser.
// Rev    : 1.0 - initial release
// ============================================================================
module ad1_axi_poller
  import ad1_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BASE_ADDR          = 0,
  parameter int OFFSET_CH0         = 0,
  parameter int OFFSET_CH1         = 4,
  parameter int DUAL_MODE          = 1,
  parameter int PERIOD_W           = 24,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic                            enable,
  input  logic [PERIOD_W-1:0]             period_cycles,
  input  logic                            clr_status,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic [31:0]                     m_axis_tdata,
`ifdef AD1_AXI_POLLER_TIMESTAMP_EN
  output logic [31:0]                     m_axis_tuser,
`endif
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            ovf_flag,
  output logic                            overrun_flag,
  output logic                            rd_err_flag
);

`ifdef AD1_AXI_POLLER_TIMESTAMP_EN
  localparam int FIFO_W = 64;
`else
  localparam int FIFO_W = 32;
`endif

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] C_ADDR_CH0 = C_M_AXI_ADDR_WIDTH'(BASE_ADDR + OFFSET_CH0);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] C_ADDR_CH1 = C_M_AXI_ADDR_WIDTH'(BASE_ADDR + OFFSET_CH1);
  localparam state_t C_AFTER_CH0 = (DUAL_MODE != 0) ? ST_AR1 : ST_PUSH;
  localparam logic [PERIOD_W-1:0] C_TICK_STEP = {{(PERIOD_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [PERIOD_W-1:0] r_tick_cnt;
  logic                w_tick;
  logic                r_pend;
  logic                w_start;
  logic                w_cap0;
  logic                w_cap1;
  logic                w_resp_err;
  logic [CH_W-1:0]     r_ch0;
  logic [CH_W-1:0]     r_ch1;
  logic                r_err;
  logic                w_in_push;
  logic                w_pop;
  logic                w_push;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [SAMPLE_W-1:0] w_sample;
  logic [FIFO_W-1:0]   w_fifo_din;
  logic [FIFO_W-1:0]   w_fifo_dout;
  logic                w_ovf_set;
  logic                w_overrun_set;
  logic                w_err_set;
  logic                w_unused_rdata;

  assign m_axi_arprot   = 3'b000;
  assign w_resp_err     = |(m_axi_rresp & RESP_SLVERR);
  assign w_unused_rdata = ^m_axi_rdata[C_M_AXI_DATA_WIDTH-1:CH_W];

  // Tick generator: one pulse every period_cycles+1 clocks while enabled.
  assign w_tick = enable && (r_tick_cnt >= period_cycles);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn || !enable || w_tick) r_tick_cnt <= '0;
    else                                     r_tick_cnt <= r_tick_cnt + C_TICK_STEP;
  end

  assign w_start       = (r_state == ST_IDLE) && r_pend && enable;
  assign w_overrun_set = w_tick && r_pend && !w_start;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn || !enable) r_pend <= 1'b0;
    else if (w_tick)               r_pend <= 1'b1;
    else if (w_start)              r_pend <= 1'b0;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  // rready is raised alongside arvalid so a same-cycle R beat is accepted.
  always_comb begin
    w_next        = r_state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_araddr  = '0;
    w_cap0        = 1'b0;
    w_cap1        = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_start) w_next = ST_AR0;
      ST_AR0: begin
        m_axi_arvalid = 1'b1;
        m_axi_rready  = 1'b1;
        m_axi_araddr  = C_ADDR_CH0;
        if (m_axi_arready) begin
          if (m_axi_rvalid) begin
            w_cap0 = 1'b1;
            w_next = C_AFTER_CH0;
          end else begin
            w_next = ST_R0;
          end
        end
      end
      ST_R0: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          w_cap0 = 1'b1;
          w_next = C_AFTER_CH0;
        end
      end
      ST_AR1: begin
        m_axi_arvalid = 1'b1;
        m_axi_rready  = 1'b1;
        m_axi_araddr  = C_ADDR_CH1;
        if (m_axi_arready) begin
          if (m_axi_rvalid) begin
            w_cap1 = 1'b1;
            w_next = ST_PUSH;
          end else begin
            w_next = ST_R1;
          end
        end
      end
      ST_R1: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          w_cap1 = 1'b1;
          w_next = ST_PUSH;
        end
      end
      ST_PUSH: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_ch0 <= '0;
      r_ch1 <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start) r_err <= 1'b0;
      if (w_cap0) begin
        r_ch0 <= m_axi_rdata[CH_W-1:0];
        r_err <= r_err | w_resp_err;
      end
      if (w_cap1) begin
        r_ch1 <= m_axi_rdata[CH_W-1:0];
        r_err <= r_err | w_resp_err;
      end
    end
  end

  assign w_sample  = pack_sample(r_ch0, (DUAL_MODE != 0) ? r_ch1 : '0);
  assign w_in_push = (r_state == ST_PUSH);
  assign w_pop     = m_axis_tvalid && m_axis_tready;
  assign w_push    = w_in_push && !r_err && (!w_fifo_full || w_pop);
  assign w_err_set = w_in_push && r_err;
  assign w_ovf_set = w_in_push && !r_err && w_fifo_full && !w_pop;

`ifdef AD1_AXI_POLLER_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_ts_lat;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_ts_cnt <= '0;
      r_ts_lat <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if ((r_state == ST_AR0) && m_axi_arready) r_ts_lat <= r_ts_cnt;
    end
  end

  assign w_fifo_din   = {r_ts_lat, w_sample};
  assign m_axis_tuser = w_fifo_dout[63:32];
`else
  assign w_fifo_din   = w_sample;
`endif

  ad1_sample_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .aresetn (s_axi_aresetn),
    .push    (w_push),
    .din     (w_fifo_din),
    .full    (w_fifo_full),
    .pop     (w_pop),
    .dout    (w_fifo_dout),
    .empty   (w_fifo_empty),
    .level   (fifo_level)
  );

  assign m_axis_tvalid = !w_fifo_empty;
  assign m_axis_tdata  = w_fifo_dout[31:0];

  // A set in the same cycle as clr_status takes priority.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      ovf_flag     <= 1'b0;
      overrun_flag <= 1'b0;
      rd_err_flag  <= 1'b0;
    end else begin
      ovf_flag     <= w_ovf_set     | (ovf_flag     & ~clr_status);
      overrun_flag <= w_overrun_set | (overrun_flag & ~clr_status);
      rd_err_flag  <= w_err_set     | (rd_err_flag  & ~clr_status);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad1_axi_poller.sv
`default_nettype none
// Testbench for ad1_axi_poller: behavioural AXI-Lite slave feeding a scoreboard,
// with a separate stream monitor popping expected samples.
module tb_ad1_axi_poller;
  import ad1_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [23:0] period_cycles;
  logic        clr_status;
  logic [3:0]  m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axis_tdata;
`ifdef AD1_AXI_POLLER_TIMESTAMP_EN
  logic [31:0] m_axis_tuser;
`endif
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [4:0]  fifo_level;
  logic        ovf_flag;
  logic        overrun_flag;
  logic        rd_err_flag;

  always #5 clk = ~clk;

  ad1_axi_poller dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .enable        (enable),
    .period_cycles (period_cycles),
    .clr_status    (clr_status),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
`ifdef AD1_AXI_POLLER_TIMESTAMP_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .ovf_flag      (ovf_flag),
    .overrun_flag  (overrun_flag),
    .rd_err_flag   (rd_err_flag)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Slave configuration and observation
  int          sl_ar_delay = 0;
  int          sl_r_delay  = 0;
  bit          sl_same     = 0;
  bit          sl_err1     = 0;
  bit          sl_inc      = 0;
  logic [11:0] sl_base0    = '0;
  logic [11:0] sl_base1    = '0;
  int          sl_polls    = 0;
  int          sl_done     = 0;
  int          exp_budget  = 0;
  int          cyc         = 0;
  int          ar_cyc_q[$];
  logic [3:0]  ar_addr_q[$];
  logic [31:0] sb_q[$];

  int          sl_st   = 0;
  int          sl_wcnt = 0;
  int          sl_rcnt = 0;
  logic [3:0]  cur_addr;
  logic [11:0] cur0;
  logic [11:0] cur1;
  bit          poll_err;

  // Present one R beat; if rready is already high the beat completes at the next edge.
  task automatic drive_r();
    logic [11:0] v;
    bit          e;
    if (cur_addr == 4'h0) v = sl_base0 + (sl_inc ? 12'(sl_polls) : 12'h000);
    else                  v = sl_base1 + (sl_inc ? 12'(sl_polls) : 12'h000);
    e = sl_err1 && (cur_addr == 4'h4);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = {20'hA5A5A, v};
    m_axi_rresp  = e ? RESP_SLVERR : RESP_OKAY;
    if (m_axi_rready) begin
      sl_st = 0;
      if (cur_addr == 4'h0) begin
        cur0     = v;
        poll_err = e;
      end else begin
        cur1     = v;
        poll_err = poll_err | e;
        sl_done++;
        if (!poll_err && exp_budget > 0) begin
          sb_q.push_back({4'h0, cur1, 4'h0, cur0});
          exp_budget--;
        end
      end
    end else begin
      sl_st = 1;
    end
  endtask

  // Slave decides its outputs at the falling edge for the following rising edge.
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = RESP_OKAY;
    forever begin
      @(negedge clk);
      cyc++;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      if (!aresetn) begin
        sl_st   = 0;
        sl_wcnt = 0;
      end else if (sl_st == 0) begin
        if (sl_wcnt > 0) begin
          chk("arvalid_hold", m_axi_arvalid, 1);
          chk("araddr_hold", m_axi_araddr, cur_addr);
        end
        if (m_axi_arvalid) begin
          if (sl_wcnt == 0) cur_addr = m_axi_araddr;
          if (sl_wcnt >= sl_ar_delay) begin
            m_axi_arready = 1'b1;
            sl_wcnt = 0;
            ar_cyc_q.push_back(cyc);
            ar_addr_q.push_back(cur_addr);
            if (cur_addr == 4'h0) sl_polls++;
            if (sl_same) drive_r();
            else begin
              sl_st   = 1;
              sl_rcnt = 0;
            end
          end else begin
            sl_wcnt++;
          end
        end else begin
          sl_wcnt = 0;
        end
      end else begin
        if (sl_rcnt < sl_r_delay) sl_rcnt++;
        else drive_r();
      end
    end
  end

  // Stream monitor: pops the scoreboard on every accepted beat.
  logic [31:0] hold_d;
  bit          hold_v = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (hold_v && m_axis_tvalid) chk("tdata_stable", m_axis_tdata, hold_d);
      hold_v = 0;
      if (aresetn && m_axis_tvalid) begin
        if (m_axis_tready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample: got 0x%0h, want none", m_axis_tdata);
          end else begin
            chk("sample", m_axis_tdata, sb_q.pop_front());
          end
        end else begin
          hold_v = 1;
          hold_d = m_axis_tdata;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
  endtask

  task automatic new_test();
    sl_polls = 0;
    sl_done  = 0;
    ar_cyc_q.delete();
    ar_addr_q.delete();
  endtask

  task automatic wait_done(input int n, input int maxc, input string nm);
    int c = 0;
    while (sl_done < n && c < maxc) begin
      step(1);
      c++;
    end
    chk(nm, sl_done >= n, 1);
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int c = 0;
    int q = 0;
    while (q < 4 && c < maxc) begin
      step(1);
      c++;
      if (!m_axi_arvalid && !m_axi_rready && (!m_axis_tvalid || !m_axis_tready)) q++;
      else q = 0;
    end
    chk(nm, q >= 4, 1);
  endtask

  initial begin
    int c;
    aresetn       = 1'b0;
    enable        = 1'b0;
    period_cycles = '0;
    clr_status    = 1'b0;
    m_axis_tready = 1'b1;
    step(4);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arprot", m_axi_arprot, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_flags", {ovf_flag, overrun_flag, rd_err_flag}, 0);
    aresetn = 1'b1;
    step(2);

    // Zero-wait slave, period 10 clocks
    new_test();
    period_cycles = 24'd9;
    sl_base0 = 12'h123; sl_base1 = 12'hABC; sl_inc = 0;
    exp_budget = 3;
    enable = 1'b1;
    wait_done(3, 200, "t1_polls");
    enable = 1'b0;
    chk("t1_tick_spacing", ar_cyc_q[2] - ar_cyc_q[0], 10);
    chk("t1_ch1_addr", ar_addr_q[1], 4'h4);
    wait_idle(100, "t1_idle");
    chk("t1_overrun", overrun_flag, 0);
    chk("t1_level", fifo_level, 0);

    // Blocking slave: arready held 40 cycles
    new_test();
    period_cycles = 24'd4;
    sl_ar_delay = 40;
    sl_base0 = 12'h321; sl_base1 = 12'h654;
    exp_budget = 2;
    enable = 1'b1;
    wait_done(1, 300, "t2_first_poll");
    enable = 1'b0;
    wait_idle(300, "t2_idle");
    chk("t2_overrun", overrun_flag, 1);
    chk("t2_polls_le2", sl_polls <= 2, 1);
    chk("t2_sb_drained", sb_q.size(), 0);
    exp_budget = 0;
    sl_ar_delay = 0;
    pulse_clr();
    chk("t2_clr_overrun", overrun_flag, 0);

    // R beat in the same cycle as arready
    new_test();
    period_cycles = 24'd20;
    sl_same = 1;
    sl_base0 = 12'h5A5; sl_base1 = 12'h3C3;
    exp_budget = 1;
    enable = 1'b1;
    wait_done(1, 100, "t3_poll");
    enable = 1'b0;
    wait_idle(100, "t3_idle");
    chk("t3_ar1_next_cycle", ar_cyc_q[1] - ar_cyc_q[0], 1);
    chk("t3_ar1_addr", ar_addr_q[1], 4'h4);
    chk("t3_sb_drained", sb_q.size(), 0);
    sl_same = 0;

    // SLVERR on CH1: sample dropped, flag sticky until cleared
    new_test();
    m_axis_tready = 1'b0;
    sl_err1 = 1;
    sl_base0 = 12'h111; sl_base1 = 12'h222;
    exp_budget = 0;
    enable = 1'b1;
    wait_done(1, 100, "t4_poll");
    enable = 1'b0;
    wait_idle(100, "t4_idle");
    chk("t4_rd_err", rd_err_flag, 1);
    chk("t4_level", fifo_level, 0);
    chk("t4_tvalid", m_axis_tvalid, 0);
    pulse_clr();
    chk("t4_clr_rd_err", rd_err_flag, 0);
    sl_err1 = 0;

    // Overflow: 20 polls into a 16-deep FIFO, then drain in order
    new_test();
    period_cycles = 24'd9;
    sl_inc = 1;
    sl_base0 = 12'h100; sl_base1 = 12'h800;
    exp_budget = 16;
    enable = 1'b1;
    wait_done(20, 400, "t5_polls");
    enable = 1'b0;
    wait_idle(100, "t5_idle");
    chk("t5_level_full", fifo_level, 16);
    chk("t5_ovf", ovf_flag, 1);
    chk("t5_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    c = 0;
    while (fifo_level != 0 && c < 100) begin
      step(1);
      c++;
    end
    step(2);
    chk("t5_drained", fifo_level, 0);
    chk("t5_sb_drained", sb_q.size(), 0);
    sl_inc = 0;

    // enable dropped while waiting in R0
    new_test();
    period_cycles = 24'd30;
    sl_r_delay = 5;
    sl_base0 = 12'h7E1; sl_base1 = 12'h1E7;
    exp_budget = 1;
    enable = 1'b1;
    c = 0;
    while (!(m_axi_rready && !m_axi_arvalid) && c < 100) begin
      step(1);
      c++;
    end
    chk("t6_reached_r0", m_axi_rready && !m_axi_arvalid, 1);
    enable = 1'b0;
    wait_idle(100, "t6_idle");
    chk("t6_one_poll", sl_done, 1);
    chk("t6_ar_count", ar_cyc_q.size(), 2);
    chk("t6_sb_drained", sb_q.size(), 0);
    sl_r_delay = 0;

    // Reset while stalled in AR1 with a sample held in the FIFO
    new_test();
    m_axis_tready = 1'b0;
    period_cycles = 24'd9;
    sl_ar_delay = 10;
    exp_budget = 0;
    enable = 1'b1;
    wait_done(1, 200, "t7_first_poll");
    c = 0;
    while (!(m_axi_arvalid && m_axi_araddr == 4'h4) && c < 100) begin
      step(1);
      c++;
    end
    chk("t7_in_ar1", m_axi_arvalid && m_axi_araddr == 4'h4, 1);
    chk("t7_level_pre", fifo_level, 1);
    chk("t7_ovf_pre", ovf_flag, 1);
    aresetn = 1'b0;
    enable  = 1'b0;
    step(1);
    chk("t7_arvalid", m_axi_arvalid, 0);
    chk("t7_rready", m_axi_rready, 0);
    chk("t7_level", fifo_level, 0);
    chk("t7_tvalid", m_axis_tvalid, 0);
    chk("t7_flags", {ovf_flag, overrun_flag, rd_err_flag}, 0);
    aresetn = 1'b1;
    sl_ar_delay = 0;
    m_axis_tready = 1'b1;
    step(20);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ad1_axi_poller.md
Name: ad1_axi_poller

Overview:
- AXI4-Lite read-only master that sits directly downstream of the Pmod AD1 AXI-Lite slave and polls its CH0/CH1 data registers at a programmable period.
- Each poll returns one packed sample word, buffered in a small FIFO and presented on an AXI4-Stream-style valid/ready output.
- Turns the register-mapped ADC into a continuous sample stream for filters and DMA, with no CPU polling.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, read address width; matches the slave's address width.
- C_M_AXI_DATA_WIDTH, 32, read data width.
- BASE_ADDR, 0, slave base added to the offsets.
- OFFSET_CH0, 0, CH0 data register offset.
- OFFSET_CH1, 4, CH1 data register offset.
- DUAL_MODE, 1, 1 = read CH1 after CH0; 0 = CH0 only.
- PERIOD_W, 24, width of the period_cycles input.
- FIFO_DEPTH, 16, sample FIFO entries; must be a power of 2, at least 2.

Ports:
- s_axi_aclk  in  1  single clock for the whole block.
- s_axi_aresetn  in  1  reset: synchronous, active-low.
- enable  in  1  polling enable.
- period_cycles  in  PERIOD_W  clocks between poll ticks, minus 1.
- clr_status  in  1  one-cycle pulse that clears the sticky flags.
- m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  C_M_AXI_DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- m_axis_tdata  out  32  {4'b0, ch1[11:0], 4'b0, ch0[11:0]}; ch1 field is 0 when DUAL_MODE=0.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf_flag  out  1  sticky: sample dropped because the FIFO was full.
- overrun_flag  out  1  sticky: tick arrived while a tick was already pending.
- rd_err_flag  out  1  sticky: a read returned rresp[1]=1.

Behaviour:
- Reset values: all outputs 0; FIFO empty; tick counter 0; no tick pending; FSM in IDLE.
- Tick counter, while enable=1:
  - counts 0..period_cycles, then wraps to 0 and emits a 1-cycle tick.
  - period_cycles=0 gives a tick every cycle.
  - enable=0 holds the counter at 0 and generates no ticks.
- Pending tick:
  - A tick sets pend.
  - A tick arriving while pend=1 sets overrun_flag; ticks are not queued beyond one.
- FSM states: IDLE, AR0, R0, AR1, R1, PUSH.
  - IDLE: if pend, clear pend and go to AR0.
  - AR0: arvalid=1, araddr=BASE_ADDR+OFFSET_CH0, held stable until arready. rready is also 1 in AR states, because the slave may assert rvalid in the same cycle as arready.
  - On the AR handshake: if the rvalid handshake happens in the same cycle, capture and go to the next phase; otherwise go to R0.
  - R0: rready=1; on rvalid, capture rdata[11:0] and rresp.
  - After CH0: go to AR1 if DUAL_MODE, else PUSH. AR1/R1 mirror AR0/R0 using OFFSET_CH1.
  - Arbitrary arready/rvalid latency is tolerated; a blocking-mode slave stalls arready for a full conversion.
  - PUSH: if any rresp in this poll had bit 1 set, set rd_err_flag and drop the sample. Else, if the FIFO is full, set ovf_flag and drop the sample. Else write the sample. Always return to IDLE.
- enable falling mid-poll: the outstanding transaction always completes (no AXI abort), the sample is pushed normally, then the FSM idles; pend is cleared.
- FIFO and stream output:
  - Sample written in cycle N gives tvalid in cycle N+1 when the FIFO was empty.
  - tdata is stable while tvalid=1 and tready=0.
  - Simultaneous push and pop when full: the pop frees the slot and the push succeeds.
- clr_status clears all three flags. If a flag-setting event occurs in the same cycle as clr_status, the set wins.
- Synchronous reset mid-transaction forces arvalid/rready low immediately and empties the FIFO; the slave is reset by the same reset.

Optional Feature:
- Macro AD1_AXI_POLLER_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps).
  - Its value is latched when the AR0 handshake completes and is stored with the sample.
  - It is output on m_axis_tuser[31:0], aligned with tdata; the FIFO is 64 bits wide.
- Undefined: no tuser port, no counter, and the FIFO is 32 bits wide.

Decomposition:
- Shared package ad1_pkg:
  - FSM state encoding.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Sample-word packing constants: CH0 at bits [11:0], CH1 at [27:16].
- One sub-module, ad1_sample_fifo:
  - Synchronous FIFO, parameterised width and depth.
  - push/full and pop/empty ports, plus level.
  - Registered output with first-word fall-through.

Test Plan:
- period_cycles=9, DUAL_MODE=1, zero-wait slave returning CH0=0x123, CH1=0xABC -> a tick every 10 clocks; tdata=0x0ABC0123; arvalid stays high until arready.
- Slave holds arready low for 40 cycles (blocking mode) with period_cycles=4 -> one sample produced, overrun_flag=1, at most one extra poll follows.
- Slave asserts rvalid in the same cycle as arready -> no R state entered, correct data captured, next araddr=0x4 in the following cycle.
- Slave returns rresp=2'b10 on CH1 -> rd_err_flag=1, FIFO level unchanged; a clr_status pulse returns the flag to 0.
- tready=0, FIFO_DEPTH=16, 20 polls -> fifo_level=16, ovf_flag=1; then tready=1 -> 16 samples drain in order.
- enable dropped while in R0; separately, reset asserted in AR1 -> the poll completes and 1 sample is pushed; after reset, arvalid=0, FIFO empty, all flags 0.
